rv32e_wb_regfile: RTL and testbench

//   Write-back stage plus 16 x 32-bit RV32E register file for the 3-stage pipeline.

---
 rtl/rv32e_pkg.sv | 25 ++
 rtl/rv32e_wb_regfile_rf_read_port.sv | 17 +
 rtl/rv32e_wb_regfile.sv | 94 +++++++++
 tb/tb_rv32e_wb_regfile.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32e_pkg.sv
// Shared types and sizes for the RV32E write-back stage and register file.
// Bypass forwarding is selected at build time with RV32E_WB_BYPASS_EN.
package rv32e_pkg;

    localparam int XLEN      = 32;
    localparam int NREGS     = 16;
    localparam int REG_IDX_W = $clog2(NREGS);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      word_t;

    // One in-flight instruction held between EX and the register array.
    typedef struct packed {
        logic     valid;
        logic     we;
        reg_idx_t rd;
        word_t    data;
    } wb_entry_t;

    // True when a pending entry will actually change architectural state.
    function automatic logic wb_writes(input wb_entry_t e);
        return e.valid & e.we & (e.rd != '0);
    endfunction

endpackage

// File: rtl/rv32e_wb_regfile_rf_read_port.sv
// One 16:1 read port of the register array; index 0 always reads as zero.
module rf_read_port
    import rv32e_pkg::*;
(
    input  word_t    regs [NREGS],
    input  reg_idx_t addr,
    output word_t    data
);

    always_comb begin
        data = regs[addr];
        if (addr == '0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/rv32e_wb_regfile.sv
// RV32E write-back register plus 16 x XLEN register file with two combinational read ports.
// Define RV32E_WB_BYPASS_EN to forward the pending WB result to reads instead of flagging a hazard.
module rv32e_wb_regfile
    import rv32e_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_we,
    input  reg_idx_t         ex_rd,
    input  word_t            ex_result,
    input  logic             wb_stall,
    input  logic             wb_flush,
    input  reg_idx_t         rs1_addr,
    input  reg_idx_t         rs2_addr,
    output word_t            rs1_data,
    output word_t            rs2_data,
    output logic             rs_hazard,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    wb_entry_t        wb_q;
    word_t            regs [NREGS];
    logic [CNT_W-1:0] retire_q;
    logic             commit;
    word_t            arr1_data;
    word_t            arr2_data;

    // A stalled entry stays put: it neither retires nor gets replaced.
    assign commit = wb_q.valid & ~wb_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q     <= '0;
            retire_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (!wb_stall) begin
                wb_q.valid <= ex_valid & ~wb_flush;
                wb_q.we    <= ex_we & ex_valid & ~wb_flush;
                wb_q.rd    <= ex_rd;
                wb_q.data  <= ex_result;
            end
            if (commit) begin
                if (wb_q.we && (wb_q.rd != '0)) begin
                    regs[wb_q.rd] <= wb_q.data;
                end
                retire_q <= retire_q + CNT_ONE;
            end
        end
    end

    assign retire_cnt = retire_q;

    rf_read_port u_rd1 (
        .regs (regs),
        .addr (rs1_addr),
        .data (arr1_data)
    );

    rf_read_port u_rd2 (
        .regs (regs),
        .addr (rs2_addr),
        .data (arr2_data)
    );

`ifdef RV32E_WB_BYPASS_EN
    // Write-first forwarding: a pending write is visible even while WB is stalled.
    logic hit1;
    logic hit2;

    always_comb begin
        hit1      = wb_writes(wb_q) & (rs1_addr == wb_q.rd);
        hit2      = wb_writes(wb_q) & (rs2_addr == wb_q.rd);
        rs1_data  = hit1 ? wb_q.data : arr1_data;
        rs2_data  = hit2 ? wb_q.data : arr2_data;
        rs_hazard = 1'b0;
    end
`else
    // Without forwarding, decode must stall until the pending write lands.
    always_comb begin
        rs1_data  = arr1_data;
        rs2_data  = arr2_data;
        rs_hazard = wb_writes(wb_q) & ((rs1_addr == wb_q.rd) | (rs2_addr == wb_q.rd));
    end
`endif

endmodule

// File: tb/tb_rv32e_wb_regfile.sv
// Directed scoreboard bench for rv32e_wb_regfile; a 4-bit-counter instance covers retire_cnt wrap.
module tb_rv32e_wb_regfile;
    import rv32e_pkg::*;

`ifdef RV32E_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // rs1(32) rs2(32) hazard(1) retire_cnt(32) retire_cnt mod 16 (4)
    localparam int EXP_W = 101;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_we;
    reg_idx_t    ex_rd;
    word_t       ex_result;
    logic        wb_stall;
    logic        wb_flush;
    reg_idx_t    rs1_addr;
    reg_idx_t    rs2_addr;
    word_t       rs1_data;
    word_t       rs2_data;
    logic        rs_hazard;
    logic [31:0] retire_cnt;
    word_t       w_rs1_data;
    word_t       w_rs2_data;
    logic        w_rs_hazard;
    logic [3:0]  w_retire_cnt;

    logic             chk_valid;
    logic [EXP_W-1:0] exp_q[$];
    int               n_checks;
    int               n_fail;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    rv32e_wb_regfile u_dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_we      (ex_we),
        .ex_rd      (ex_rd),
        .ex_result  (ex_result),
        .wb_stall   (wb_stall),
        .wb_flush   (wb_flush),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rs_hazard  (rs_hazard),
        .retire_cnt (retire_cnt)
    );

    rv32e_wb_regfile #(.CNT_W(4)) u_dut_w (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_we      (ex_we),
        .ex_rd      (ex_rd),
        .ex_result  (ex_result),
        .wb_stall   (wb_stall),
        .wb_flush   (wb_flush),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (w_rs1_data),
        .rs2_data   (w_rs2_data),
        .rs_hazard  (w_rs_hazard),
        .retire_cnt (w_retire_cnt)
    );

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic we, input logic [3:0] rd,
                        input logic [31:0] res, input logic stall, input logic flush);
        ex_valid  = v;
        ex_we     = we;
        ex_rd     = rd;
        ex_result = res;
        wb_stall  = stall;
        wb_flush  = flush;
        @(posedge clk);
        #2;
        ex_valid  = 1'b0;
        ex_we     = 1'b0;
        wb_stall  = 1'b0;
        wb_flush  = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Present read addresses and queue the expected view of the current state.
    task automatic check(input logic [3:0] a1, input logic [3:0] a2,
                         input logic [31:0] e1, input logic [31:0] e2,
                         input logic ehz, input logic [31:0] ecnt);
        rs1_addr = a1;
        rs2_addr = a2;
        exp_q.push_back({e1, e2, ehz, ecnt, ecnt[3:0]});
        chk_valid = 1'b1;
        @(negedge clk);
        #1;
        chk_valid = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%08h required=%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: actual=0 entries required=1 entry");
            end else begin
                logic [EXP_W-1:0] e;
                e = exp_q.pop_front();
                cmp("rs1_data", rs1_data, e[100:69]);
                cmp("rs2_data", rs2_data, e[68:37]);
                cmp("rs_hazard", {31'b0, rs_hazard}, {31'b0, e[36]});
                cmp("retire_cnt", retire_cnt, e[35:4]);
                cmp("retire_cnt_w4", {28'b0, w_retire_cnt}, {28'b0, e[3:0]});
                cmp("w4_rs1_data", w_rs1_data, e[100:69]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        chk_valid = 1'b0;
        rst       = 1'b1;
        ex_valid  = 1'b0;
        ex_we     = 1'b0;
        ex_rd     = '0;
        ex_result = '0;
        wb_stall  = 1'b0;
        wb_flush  = 1'b0;
        rs1_addr  = '0;
        rs2_addr  = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        check(4'd0, 4'd1, 32'h0, 32'h0, 1'b0, 32'd0);

        // Populate one register, then reset must clear it and the counter.
        step(1'b1, 1'b1, 4'd9, 32'h99, 1'b0, 1'b0);
        idle();
        check(4'd9, 4'd9, 32'h99, 32'h99, 1'b0, 32'd1);
        pulse_reset();
        for (int i = 0; i < 16; i += 2) begin
            check(4'(i), 4'(i + 1), 32'h0, 32'h0, 1'b0, 32'd0);
        end

        // Basic write: pending one cycle, visible in the array after commit.
        step(1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        check(4'd5, 4'd0, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, !BYP, 32'd0);
        idle();
        check(4'd5, 4'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'd1);

        // x0 write is dropped but retires.
        step(1'b1, 1'b1, 4'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        check(4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 32'd1);
        idle();
        check(4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 32'd2);

        // Stall for 3 cycles; stall beats flush and blocks new captures.
        step(1'b1, 1'b1, 4'd3, 32'h11, 1'b0, 1'b0);
        check(4'd3, 4'd3, BYP ? 32'h11 : 32'h0, BYP ? 32'h11 : 32'h0, !BYP, 32'd2);
        step(1'b1, 1'b1, 4'd3, 32'h55, 1'b1, 1'b0);
        step(1'b1, 1'b1, 4'd2, 32'h66, 1'b1, 1'b1);
        step(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        check(4'd3, 4'd3, BYP ? 32'h11 : 32'h0, BYP ? 32'h11 : 32'h0, !BYP, 32'd2);
        idle();
        check(4'd3, 4'd2, 32'h11, 32'h0, 1'b0, 32'd3);

        // Flush squashes the capture: no write, no retire.
        step(1'b1, 1'b1, 4'd4, 32'h22, 1'b0, 1'b1);
        check(4'd4, 4'd0, 32'h0, 32'h0, 1'b0, 32'd3);
        idle();
        check(4'd4, 4'd4, 32'h0, 32'h0, 1'b0, 32'd3);

        // Same-cycle RAW on rd=7 over an older value.
        step(1'b1, 1'b1, 4'd7, 32'h70, 1'b0, 1'b0);
        idle();
        step(1'b1, 1'b1, 4'd7, 32'h77, 1'b0, 1'b0);
        check(4'd7, 4'd2, BYP ? 32'h77 : 32'h70, 32'h0, !BYP, 32'd4);
        idle();
        check(4'd7, 4'd7, 32'h77, 32'h77, 1'b0, 32'd5);

        // RAW seen only through read port 2.
        step(1'b1, 1'b1, 4'd5, 32'h55, 1'b0, 1'b0);
        check(4'd1, 4'd5, 32'h0, BYP ? 32'h55 : 32'hDEADBEEF, !BYP, 32'd5);
        idle();
        check(4'd5, 4'd1, 32'h55, 32'h0, 1'b0, 32'd6);

        // Back-to-back writes: first lands while second is pending.
        step(1'b1, 1'b1, 4'd6, 32'hA1A1A1A1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'd8, 32'hB2B2B2B2, 1'b0, 1'b0);
        check(4'd6, 4'd8, 32'hA1A1A1A1, BYP ? 32'hB2B2B2B2 : 32'h0, !BYP, 32'd7);
        idle();
        check(4'd8, 4'd6, 32'hB2B2B2B2, 32'hA1A1A1A1, 1'b0, 32'd8);

        // Reset with an entry pending: it is discarded.
        step(1'b1, 1'b1, 4'd10, 32'hAA, 1'b0, 1'b0);
        pulse_reset();
        check(4'd10, 4'd5, 32'h0, 32'h0, 1'b0, 32'd0);

        // 16 commits: the 4-bit counter reaches 15 then wraps to 0.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b1, 4'd1, 32'(i), 1'b0, 1'b0);
        end
        check(4'd1, 4'd0, BYP ? 32'd16 : 32'd15, 32'h0, !BYP, 32'd15);
        idle();
        check(4'd1, 4'd1, 32'd16, 32'd16, 1'b0, 32'd16);

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual=%0d entries required=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
